mul_div_unit: RTL



---
 rtl/mul_div_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage; writes {hi, lo} with one strobe.
// Define MDU_FAST_MUL_EN for a single-step multiply; division is always 32-cycle restoring.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        cancel_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Working datapath: r_work is {accumulator, multiplier} for MUL, {remainder, quotient} for DIV.
  logic [63:0] r_work;
  logic [31:0] r_opnd;
  logic [5:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_div;
  logic        w_signed;
  logic        w_div_zero;
  logic        w_accept;
  logic        w_last;
  logic        w_neg_q;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic [32:0] w_div_trial;
  logic        w_div_ok;
  logic [31:0] w_div_rem;
  logic [31:0] w_div_quo;
`ifdef MDU_FAST_MUL_EN
  logic [63:0] w_fast_prod;
`endif

  assign w_is_div   = op_i[1];
  assign w_signed   = ~op_i[0];
  assign w_div_zero = w_is_div & (src_b_i == 32'd0);
  assign w_accept   = (r_state == S_IDLE) & start_i & ~cancel_i;
  assign w_last     = (r_cnt == 6'd31);
  assign w_neg_q    = w_signed & (src_a_i[31] ^ src_b_i[31]);

  // Two's-complement negation of 0x80000000 yields its own unsigned magnitude.
  assign w_abs_a = (w_signed & src_a_i[31]) ? -src_a_i : src_a_i;
  assign w_abs_b = (w_signed & src_b_i[31]) ? -src_b_i : src_b_i;

  // Shift-add: add multiplicand to the upper half when the current multiplier bit is set.
  assign w_mul_sum  = {1'b0, r_work[63:32]} + {1'b0, (r_work[0] ? r_opnd : 32'd0)};
  assign w_mul_step = {w_mul_sum, r_work[31:1]};

  // Restoring step: shift in the next dividend bit, keep the subtraction only if it fits.
  assign w_div_trial = {r_work[63:32], r_work[31]} - {1'b0, r_opnd};
  assign w_div_ok    = ~w_div_trial[32];
  assign w_div_rem   = w_div_ok ? w_div_trial[31:0] : {r_work[62:32], r_work[31]};
  assign w_div_quo   = {r_work[30:0], w_div_ok};

`ifdef MDU_FAST_MUL_EN
  assign w_fast_prod = {32'd0, w_abs_a} * {32'd0, w_abs_b};
`endif

  assign hi_o = r_hi;
  assign lo_o = r_lo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output and w_next gets a default first so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    stall_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    hilo_we_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall_o = 1'b1;
          if (w_is_div) begin
            w_next = w_div_zero ? S_DONE : S_DIV;
          end else begin
`ifdef MDU_FAST_MUL_EN
            w_next = S_DONE;
`else
            w_next = S_MUL;
`endif
          end
        end
      end
      S_MUL, S_DIV: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        if (cancel_i)    w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        hilo_we_o = ~cancel_i;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work  <= 64'd0;
      r_opnd  <= 32'd0;
      r_cnt   <= 6'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= 6'd0;
            r_neg_q <= w_neg_q;
            r_neg_r <= w_signed & src_a_i[31];
            if (w_is_div) begin
              r_opnd <= w_abs_b;
              r_work <= {32'd0, w_abs_a};
              if (w_div_zero) begin
                r_hi <= src_a_i;
                r_lo <= 32'hFFFF_FFFF;
              end
            end else begin
              r_opnd <= w_abs_a;
              r_work <= {32'd0, w_abs_b};
`ifdef MDU_FAST_MUL_EN
              {r_hi, r_lo} <= w_neg_q ? -w_fast_prod : w_fast_prod;
`endif
            end
          end
        end
        S_MUL: begin
          if (!cancel_i) begin
            r_work <= w_mul_step;
            r_cnt  <= r_cnt + 6'd1;
            if (w_last) {r_hi, r_lo} <= r_neg_q ? -w_mul_step : w_mul_step;
          end
        end
        S_DIV: begin
          if (!cancel_i) begin
            r_work <= {w_div_rem, w_div_quo};
            r_cnt  <= r_cnt + 6'd1;
            if (w_last) begin
              r_hi <= r_neg_r ? -w_div_rem : w_div_rem;
              r_lo <= r_neg_q ? -w_div_quo : w_div_quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
